// File: rtl/dma_pkg.sv
// Types and constants shared by the DMA read and write engines.
package dma_pkg;

  typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DONE} s2mm_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         BOUNDARY_4K   = 4096;

  function automatic logic [2:0] popcount4(input logic [3:0] k);
    return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction

endpackage

// File: rtl/s2mm_fifo.sv
// First-word-fall-through beat buffer; rdata shows the head entry whenever !empty.
module s2mm_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/s2mm_top.sv
// Stream-to-memory write engine: buffers one AXI-Stream packet per command and
// writes it out as 4KB-safe INCR bursts, one burst outstanding at a time.
module s2mm_top
  import dma_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  output logic        sts_valid,
  output logic [31:0] sts_bytes,
  output logic        sts_err,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic        m_axi_wlast,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  s2mm_state_t   state_q, state_d;
  logic [31:0]   cur_addr_q, cur_addr_d, bytes_q, bytes_d;
  logic [31:0]   awaddr_q, awaddr_d, sts_bytes_q, sts_bytes_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [BW-1:0] blen_q, blen_d, beat_q, beat_d;
  logic          err_q, err_d, last_seen_q, last_seen_d;
  logic          cmd_ready_q, cmd_ready_d, sts_valid_q, sts_valid_d, sts_err_q, sts_err_d;
  logic [CW-1:0] fifo_count;
  logic [36:0]   fifo_rdata;
  logic          fifo_full, fifo_empty, push, pop, cmd_take, last_beat;
  logic          fifo_tlast_unused;
  logic [12:0]   rem4k, cap, blen_calc;

  s2mm_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(37)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_tlast_unused = fifo_rdata[36];
  assign s_axis_tready = (state_q != IDLE) && !fifo_full && !last_seen_q;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axi_wvalid && m_axi_wready;
  assign cmd_take      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign last_beat     = (beat_q == blen_q - BW'(1));

  // Beats left before the next 4KB page; addresses are word aligned so this is >= 1.
  assign rem4k     = (13'(BOUNDARY_4K) - {1'b0, cur_addr_q[11:0]}) >> 2;
  assign cap       = (rem4k >= 13'(MAX_BURST)) ? 13'(MAX_BURST) : rem4k;
  assign blen_calc = (13'(fifo_count) < cap) ? 13'(fifo_count) : cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_take) state_d = FILL;
      FILL: begin
        if ((13'(fifo_count) >= cap) || (last_seen_q && !fifo_empty)) state_d = AW;
        else if (last_seen_q)                                           state_d = DONE;
      end
      AW:   if (m_axi_awready) state_d = W;
      W:    if (pop && last_beat) state_d = B;
      B:    if (m_axi_bvalid) state_d = (last_seen_q && fifo_empty) ? DONE : FILL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d  = cur_addr_q;
    bytes_d     = bytes_q;
    err_d       = err_q;
    last_seen_d = last_seen_q;
    blen_d      = blen_q;
    beat_d      = beat_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    sts_bytes_d = sts_bytes_q;
    sts_err_d   = sts_err_q;
    if (cmd_take) begin
      cur_addr_d  = cmd_addr;
      bytes_d     = '0;
      err_d       = 1'b0;
      last_seen_d = 1'b0;
    end
    if (push) begin
      bytes_d = bytes_q + 32'(popcount4(s_axis_tkeep));
      if (s_axis_tlast) last_seen_d = 1'b1;
    end
    if (state_q == FILL && state_d == AW) begin
      blen_d   = blen_calc[BW-1:0];
      beat_d   = '0;
      awaddr_d = cur_addr_q;
      awlen_d  = 8'(blen_calc - 13'd1);
    end
    if (pop) begin
      beat_d = beat_q + BW'(1);
      if (last_beat) cur_addr_d = cur_addr_q + (32'(blen_q) << 2);
    end
    if (state_q == B && m_axi_bvalid && m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
    if (state_d == DONE) begin
      sts_bytes_d = bytes_d;
      sts_err_d   = err_d;
    end
  end

  // cmd_ready is registered so it stays low while reset is asserted.
  assign cmd_ready_d = (state_d == IDLE);
  assign sts_valid_d = (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      bytes_q     <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      blen_q      <= '0;
      beat_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      sts_bytes_q <= '0;
      sts_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      sts_valid_q <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      bytes_q     <= bytes_d;
      err_q       <= err_d;
      last_seen_q <= last_seen_d;
      blen_q      <= blen_d;
      beat_q      <= beat_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      sts_bytes_q <= sts_bytes_d;
      sts_err_q   <= sts_err_d;
      cmd_ready_q <= cmd_ready_d;
      sts_valid_q <= sts_valid_d;
    end
  end

  always_comb begin
    cmd_ready     = cmd_ready_q;
    sts_valid     = sts_valid_q;
    sts_bytes     = sts_bytes_q;
    sts_err       = sts_err_q;
    m_axi_awvalid = (state_q == AW);
    m_axi_awaddr  = awaddr_q;
    m_axi_awlen   = awlen_q;
    m_axi_wvalid  = (state_q == W) && !fifo_empty;
    m_axi_wdata   = m_axi_wvalid ? fifo_rdata[31:0] : '0;
    m_axi_wstrb   = m_axi_wvalid ? fifo_rdata[35:32] : '0;
    m_axi_wlast   = m_axi_wvalid && last_beat;
    m_axi_bready  = (state_q == B);
  end

endmodule

// File: tb/tb_s2mm_top.sv
// Scoreboard bench for s2mm_top: directed packets with expected bursts, beats and status queued up front.
module tb_s2mm_top;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic        sts_valid, sts_err;
  logic [31:0] sts_bytes;
  logic [31:0] m_axi_awaddr, m_axi_wdata, s_axis_tdata;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [3:0]  m_axi_wstrb, s_axis_tkeep;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready, s_axis_tvalid, s_axis_tready, s_axis_tlast;

  always #5 clk = ~clk;

  s2mm_top #(.MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .sts_valid(sts_valid), .sts_bytes(sts_bytes), .sts_err(sts_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_wlast(m_axi_wlast),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast)
  );

  typedef struct {logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct {logic [31:0] data; logic [3:0] strb;} w_t;
  typedef struct {logic [31:0] bytes; logic err;} sts_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  sts_t       exp_sts[$];
  int         len_q[$];
  logic [1:0] bresp_q[$];

  int n_checks = 0;
  int n_fails  = 0;
  bit bp = 1'b0;
  int w_seen = 0;
  int bursts_done = 0;
  int b_issued = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic int pc(input logic [3:0] k);
    return int'(k[0]) + int'(k[1]) + int'(k[2]) + int'(k[3]);
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_sts_valid"}, 32'(sts_valid), 0);
    chk({tag, "_sts_bytes"}, sts_bytes, 0);
    chk({tag, "_sts_err"}, 32'(sts_err), 0);
    chk({tag, "_awvalid"}, 32'(m_axi_awvalid), 0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 0);
    chk({tag, "_awlen"}, 32'(m_axi_awlen), 0);
    chk({tag, "_wvalid"}, 32'(m_axi_wvalid), 0);
    chk({tag, "_wlast"}, 32'(m_axi_wlast), 0);
    chk({tag, "_wdata"}, m_axi_wdata, 0);
    chk({tag, "_wstrb"}, 32'(m_axi_wstrb), 0);
    chk({tag, "_bready"}, 32'(m_axi_bready), 0);
    chk({tag, "_tready"}, 32'(s_axis_tready), 0);
  endtask

  task automatic issue_cmd(input logic [31:0] a);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    cmd_addr = a;
    cmd_valid = 1'b1;
    do begin @(negedge clk); guard++; end while (!cmd_ready && guard < 100);
    chk("cmd_accept_in_time", 32'(guard < 100), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [3:0] last_keep, input bit sparse, output int bytes);
    logic [31:0] d;
    logic [3:0]  k;
    int          guard;
    bytes = 0;
    for (int i = 0; i < n; i++) begin
      if (bp) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      d = $urandom;
      k = (i == n - 1) ? last_keep : (sparse ? 4'($urandom_range(0, 15)) : 4'hF);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      exp_w.push_back('{d, k});
      bytes += pc(k);
      guard = 0;
      do begin @(negedge clk); guard++; end while (!s_axis_tready && guard < 2000);
      if (guard >= 2000) begin
        chk("tready_in_time", 32'(guard < 2000), 1);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while ((exp_sts.size() > 0 || exp_aw.size() > 0 || exp_w.size() > 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 32'(guard < 5000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // AW channel: expected burst, 4KB safety, stability while stalled.
  initial begin : aw_mon
    logic hold;
    logic [31:0] haddr;
    aw_t e;
    hold = 1'b0;
    haddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          chk("awvalid_stable", 32'(m_axi_awvalid), 1);
          chk("awaddr_stable", m_axi_awaddr, haddr);
        end
        if (m_axi_awvalid && m_axi_awready) begin
          chk("aw_expected", 32'(exp_aw.size() > 0), 1);
          chk("aw_no_4k_cross",
              32'((32'(m_axi_awaddr[11:0]) + (32'(m_axi_awlen) + 1) * 4) <= 4096), 1);
          if (exp_aw.size() > 0) begin
            e = exp_aw.pop_front();
            chk("awaddr", m_axi_awaddr, e.addr);
            chk("awlen", 32'(m_axi_awlen), 32'(e.len));
            len_q.push_back(int'(e.len));
          end
        end
        hold  = m_axi_awvalid && !m_axi_awready;
        haddr = m_axi_awaddr;
      end
    end
  end

  // W channel: data order, strobes, wlast position, stability, and tready while full.
  initial begin : w_mon
    int idx, accepted, pops, occ;
    logic hold, want_last;
    logic [31:0] hdata;
    w_t e;
    idx = 0; accepted = 0; pops = 0; hold = 1'b0; hdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idx = 0; accepted = 0; pops = 0; hold = 1'b0;
      end else begin
        occ = accepted - pops;
        if (occ >= FIFO_DEPTH) chk("tready_low_when_full", 32'(s_axis_tready), 0);
        if (hold) begin
          chk("wvalid_stable", 32'(m_axi_wvalid), 1);
          chk("wdata_stable", m_axi_wdata, hdata);
        end
        if (s_axis_tvalid && s_axis_tready) accepted++;
        if (m_axi_wvalid && m_axi_wready) begin
          chk("w_after_aw", 32'(len_q.size() > 0), 1);
          chk("w_expected", 32'(exp_w.size() > 0), 1);
          if (exp_w.size() > 0 && len_q.size() > 0) begin
            e = exp_w.pop_front();
            chk("wdata", m_axi_wdata, e.data);
            chk("wstrb", 32'(m_axi_wstrb), 32'(e.strb));
            want_last = (idx == len_q[0]);
            chk("wlast", 32'(m_axi_wlast), 32'(want_last));
            if (want_last) begin
              void'(len_q.pop_front());
              idx = 0;
              bursts_done++;
            end else idx++;
          end
          pops++;
          w_seen++;
        end
        hold  = m_axi_wvalid && !m_axi_wready;
        hdata = m_axi_wdata;
      end
    end
  end

  initial begin : sts_mon
    logic prev;
    sts_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (prev) chk("sts_one_cycle", 32'(sts_valid), 0);
        if (sts_valid) begin
          chk("sts_expected", 32'(exp_sts.size() > 0), 1);
          if (exp_sts.size() > 0) begin
            e = exp_sts.pop_front();
            chk("sts_bytes", sts_bytes, e.bytes);
            chk("sts_err", 32'(sts_err), 32'(e.err));
          end
        end
        prev = sts_valid;
      end
    end
  end

  initial begin : b_resp
    int d, guard;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n && bursts_done > b_issued) begin
        d = bp ? $urandom_range(0, 10) : 0;
        repeat (d) @(negedge clk);
        @(posedge clk); #1;
        m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        m_axi_bvalid = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!m_axi_bready && rst_n && guard < 1000);
        chk("bready_in_time", 32'(guard < 1000), 1);
        @(posedge clk); #1;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        b_issued++;
      end
    end
  end

  initial begin : rdy_drv
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_axi_awready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      m_axi_wready  = bp ? ($urandom_range(0, 4) == 0) : 1'b1;
    end
  end

  initial begin : main
    int bytes, base, guard;
    cmd_valid = 1'b0; cmd_addr = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 1);

    // Single burst, packet ends exactly on the burst.
    exp_aw.push_back('{32'h1000, 8'd15});
    issue_cmd(32'h1000);
    send_pkt(16, 4'hF, 1'b0, bytes);
    exp_sts.push_back('{32'd64, 1'b0});
    wait_idle("single_burst_done");

    // Multi-burst with partial last beat.
    exp_aw.push_back('{32'h2000, 8'd15});
    exp_aw.push_back('{32'h2040, 8'd15});
    exp_aw.push_back('{32'h2080, 8'd4});
    issue_cmd(32'h2000);
    send_pkt(37, 4'h3, 1'b0, bytes);
    exp_sts.push_back('{32'd146, 1'b0});
    wait_idle("multi_burst_done");

    // Packet straddling a 4KB page.
    exp_aw.push_back('{32'h0FF8, 8'd1});
    exp_aw.push_back('{32'h1000, 8'd5});
    issue_cmd(32'h0FF8);
    send_pkt(8, 4'hF, 1'b0, bytes);
    exp_sts.push_back('{32'd32, 1'b0});
    wait_idle("boundary_done");

    // Random backpressure, sparse strobes, zero-keep last beat.
    bp = 1'b1;
    for (int i = 0; i < 4; i++) exp_aw.push_back('{32'h4000 + 32'(i * 64), 8'd15});
    exp_aw.push_back('{32'h4100, 8'd5});
    issue_cmd(32'h4000);
    send_pkt(70, 4'h0, 1'b1, bytes);
    exp_sts.push_back('{32'(bytes), 1'b0});
    wait_idle("backpressure_done");
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Error on the second of three bursts.
    bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b00);
    for (int i = 0; i < 3; i++) exp_aw.push_back('{32'h5000 + 32'(i * 64), 8'd15});
    issue_cmd(32'h5000);
    send_pkt(48, 4'hF, 1'b0, bytes);
    exp_sts.push_back('{32'd192, 1'b1});
    wait_idle("error_done");

    // Reset in the middle of the W phase.
    base = w_seen;
    exp_aw.push_back('{32'h7000, 8'd15});
    issue_cmd(32'h7000);
    send_pkt(16, 4'hF, 1'b0, bytes);
    guard = 0;
    while (w_seen < base + 5 && guard < 200) begin @(negedge clk); guard++; end
    chk("reached_mid_w", 32'(guard < 200), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_w_reset");
    exp_aw.delete();
    exp_w.delete();
    exp_sts.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_aw.push_back('{32'h3000, 8'd3});
    issue_cmd(32'h3000);
    send_pkt(4, 4'hF, 1'b0, bytes);
    exp_sts.push_back('{32'd16, 1'b0});
    wait_idle("after_reset_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
